omsp_hmac_msg_frontend: RTL and testbench

//  Responder side of the HMAC engine command interface driven by the Sancus HMAC

---
 rtl/omsp_hmac_msg_frontend_if.sv | 32 +++
 rtl/omsp_hmac_msg_frontend.sv | 181 ++++++++++++++++++
 tb/tb_omsp_hmac_msg_frontend.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/omsp_hmac_msg_frontend_if.sv
// Command, block and digest signals between the HMAC controller/compression core
// and the message frontend. The controller/core side uses master, the frontend slave.
interface omsp_hmac_msg_frontend_if #(
    parameter int DIGEST_WORDS = 16
);
    logic                        hmac_reset;
    logic                        hmac_start_continue;
    logic                        hmac_data_available;
    logic                        hmac_data_is_long;
    logic [15:0]                 data_in;
    logic                        hmac_busy;
    logic [15:0]                 hmac_out;
    logic                        hmac_error;
    logic                        blk_valid;
    logic                        blk_first;
    logic [511:0]                blk_data;
    logic                        blk_ready;
    logic                        core_busy;
    logic [DIGEST_WORDS*16-1:0]  digest;

    modport master (
        output hmac_reset, hmac_start_continue, hmac_data_available, hmac_data_is_long,
               data_in, blk_ready, core_busy, digest,
        input  hmac_busy, hmac_out, hmac_error, blk_valid, blk_first, blk_data
    );

    modport slave (
        input  hmac_reset, hmac_start_continue, hmac_data_available, hmac_data_is_long,
               data_in, blk_ready, core_busy, digest,
        output hmac_busy, hmac_out, hmac_error, blk_valid, blk_first, blk_data
    );
endinterface

// File: rtl/omsp_hmac_msg_frontend.sv
// Packs 16-bit/8-bit message commands into SHA-256 blocks, pads and appends the
// bit length, hands blocks to the compression core and serves the digest back.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | fresh context, no data yet; accepts data/finalize strobes
// S_ABSORB | collecting message bytes into blk_data
// S_SEND   | blk_valid high, waiting for blk_ready
// S_WAIT   | block accepted, waiting for core_busy to drop
// S_PAD    | writing 0x80 / zeros / length into the current block
// S_OUTPUT | digest served on hmac_out, advance strobes step the word index
module omsp_hmac_msg_frontend #(
    parameter int DIGEST_WORDS = 16,
    parameter int LEN_W        = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    omsp_hmac_msg_frontend_if.slave   bus
);
    localparam int DW   = DIGEST_WORDS * 16;
    localparam int DI_W = $clog2(DIGEST_WORDS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABSORB = 3'd1;
    localparam logic [2:0] S_SEND   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_PAD    = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    logic [2:0]       state, state_next;
    logic [5:0]       bp, bp_next, bi;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0]   len_sum;
    logic [63:0]      len64;
    logic             first, fin, pad_pending, short_seen;
    logic [DI_W-1:0]  di, di_next, sel_idx;
    logic             busy, busy_next, error;
    logic [15:0]      out_word, sel_word;
    logic [DW-1:0]    dshift;
    logic [511:0]     blk_data, blk_next;

    logic strobe, in_absorb, data_ok, word_bad, fin_cmd, adv_cmd, out_data_err;
    logic busy_err, accept, err_set, fills, sat, len_fits;

    assign strobe    = bus.hmac_start_continue;
    assign in_absorb = (state == S_IDLE) || (state == S_ABSORB);
    assign busy_err  = strobe && busy;

    assign word_bad     = strobe && !busy && in_absorb && bus.hmac_data_available &&
                          bus.hmac_data_is_long && (bp[0] || short_seen);
    assign data_ok      = strobe && !busy && in_absorb && bus.hmac_data_available && !word_bad;
    assign fin_cmd      = strobe && !busy && in_absorb && !bus.hmac_data_available;
    assign adv_cmd      = strobe && !busy && (state == S_OUTPUT) && !bus.hmac_data_available;
    assign out_data_err = strobe && !busy && (state == S_OUTPUT) && bus.hmac_data_available;
    assign accept       = data_ok || fin_cmd || adv_cmd;

    assign bp_next = bp + {4'b0000, bus.hmac_data_is_long, ~bus.hmac_data_is_long};
    assign fills   = (bp_next == 6'd0);
    assign len_sum = {1'b0, len} + {{(LEN_W-4){1'b0}}, bus.hmac_data_is_long,
                                    ~bus.hmac_data_is_long, 3'b000};
    assign sat     = len_sum[LEN_W];
    assign len64   = 64'(len);
    assign err_set = busy_err || word_bad || out_data_err || (data_ok && sat);

    // the second pad block of an overflowing message carries only the length
    assign len_fits = pad_pending || (bp <= 6'd55);

    assign di_next  = (di == DI_W'(DIGEST_WORDS - 1)) ? '0 : di + DI_W'(1);
    assign sel_idx  = (state == S_OUTPUT) ? di_next : '0;
    assign dshift   = bus.digest << {sel_idx, 4'b0000};
    assign sel_word = dshift[DW-1 -: 16];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ABSORB: begin
                if (data_ok)      state_next = fills ? S_SEND : S_ABSORB;
                else if (fin_cmd) state_next = S_PAD;
            end
            S_SEND:  if (bus.blk_ready) state_next = S_WAIT;
            S_WAIT: begin
                if (!bus.core_busy) begin
                    if (pad_pending) state_next = S_PAD;
                    else if (fin)    state_next = S_OUTPUT;
                    else             state_next = S_ABSORB;
                end
            end
            S_PAD:    state_next = S_SEND;
            S_OUTPUT: state_next = S_OUTPUT;
            default:  state_next = S_IDLE;
        endcase
    end

    assign busy_next = accept || (state_next == S_SEND) || (state_next == S_WAIT) ||
                       (state_next == S_PAD);

    always_comb begin
        blk_next = blk_data;
        bi       = '0;
        for (int i = 0; i < 64; i++) begin
            bi = 6'(i);
            if (data_ok) begin
                if (bi == bp)
                    blk_next[511-8*i -: 8] = bus.hmac_data_is_long ? bus.data_in[15:8]
                                                                   : bus.data_in[7:0];
                else if (bus.hmac_data_is_long && (bi == bp + 6'd1))
                    blk_next[511-8*i -: 8] = bus.data_in[7:0];
            end else if (state == S_PAD) begin
                if (pad_pending || (bi > bp)) blk_next[511-8*i -: 8] = 8'h00;
                else if (bi == bp)            blk_next[511-8*i -: 8] = 8'h80;
                if (len_fits && (i >= 56))    blk_next[511-8*i -: 8] = len64[8*(63-i) +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bp          <= '0;
            len         <= '0;
            first       <= 1'b1;
            fin         <= 1'b0;
            pad_pending <= 1'b0;
            short_seen  <= 1'b0;
            di          <= '0;
            busy        <= 1'b0;
            out_word    <= '0;
            error       <= 1'b0;
            blk_data    <= '0;
        end else if (bus.hmac_reset) begin
            state       <= S_IDLE;
            bp          <= '0;
            len         <= '0;
            first       <= 1'b1;
            fin         <= 1'b0;
            pad_pending <= 1'b0;
            short_seen  <= 1'b0;
            di          <= '0;
            busy        <= 1'b0;
            out_word    <= '0;
            error       <= 1'b0;
            blk_data    <= '0;
        end else begin
            state    <= state_next;
            busy     <= busy_next;
            blk_data <= blk_next;
            if (err_set) error <= 1'b1;
            if (data_ok) begin
                bp  <= bp_next;
                len <= sat ? '1 : len_sum[LEN_W-1:0];
                if (!bus.hmac_data_is_long) short_seen <= 1'b1;
            end
            if ((state == S_SEND) && bus.blk_ready) first <= 1'b0;
            if (state == S_PAD) begin
                if (pad_pending) begin
                    pad_pending <= 1'b0;
                    fin         <= 1'b1;
                end else if (bp <= 6'd55) begin
                    fin <= 1'b1;
                end else begin
                    pad_pending <= 1'b1;
                end
            end
            if ((state == S_WAIT) && (state_next == S_OUTPUT)) begin
                di       <= '0;
                out_word <= sel_word;
            end
            if (adv_cmd) begin
                di       <= di_next;
                out_word <= sel_word;
            end
        end
    end

    assign bus.hmac_busy  = busy;
    assign bus.hmac_out   = out_word;
    assign bus.hmac_error = error;
    assign bus.blk_valid  = (state == S_SEND);
    assign bus.blk_first  = (state == S_SEND) && first;
    assign bus.blk_data   = blk_data;
endmodule

// File: tb/tb_omsp_hmac_msg_frontend.sv
// Directed bench for the HMAC message frontend: a small core model accepts
// blocks with a fixed busy time while the expected blocks and digest words are hand-built.
module tb_omsp_hmac_msg_frontend;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    omsp_hmac_msg_frontend_if bus();
    omsp_hmac_msg_frontend dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // SHA-256("abc")
    localparam logic [255:0] DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    logic [15:0] dig_words [16] = '{16'hba78, 16'h16bf, 16'h8f01, 16'hcfea,
                                    16'h4141, 16'h40de, 16'h5dae, 16'h2223,
                                    16'hb003, 16'h61a3, 16'h9617, 16'h7a9c,
                                    16'hb410, 16'hff61, 16'hf200, 16'h15ad};

    int checks = 0;
    int errors = 0;
    bit core_en;
    int core_lat = 3;
    int busy_cnt;
    logic [511:0] blk_q [$];
    bit           first_q [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            bus.blk_ready = 1'b0;
            bus.core_busy = 1'b0;
            busy_cnt      = 0;
        end else if (bus.blk_ready) begin
            bus.blk_ready = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) bus.core_busy = 1'b0;
        end else if (core_en && bus.blk_valid) begin
            bus.blk_ready = 1'b1;
            bus.core_busy = 1'b1;
            busy_cnt      = core_lat;
            blk_q.push_back(bus.blk_data);
            first_q.push_back(bus.blk_first);
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic avail, input logic is_long, input logic [15:0] d);
        @(negedge clk);
        bus.hmac_start_continue = 1'b1;
        bus.hmac_data_available = avail;
        bus.hmac_data_is_long   = is_long;
        bus.data_in             = d;
        @(negedge clk);
        bus.hmac_start_continue = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (bus.hmac_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 512'(bus.hmac_busy), 512'd0);
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        cmd(1'b1, 1'b1, w);
        wait_ready("word_ready", n);
    endtask

    task automatic clear_ctx();
        @(negedge clk);
        bus.hmac_reset = 1'b1;
        @(negedge clk);
        bus.hmac_reset = 1'b0;
        blk_q.delete();
        first_q.delete();
    endtask

    task automatic pop_blk(input string tag, input logic [511:0] exp, input bit exp_first);
        logic [511:0] got;
        bit           gf;
        got = '1;
        gf  = ~exp_first;
        if (blk_q.size() > 0) begin
            got = blk_q.pop_front();
            gf  = first_q.pop_front();
        end
        check(tag, got, exp);
        check({tag, "_first"}, 512'(gf), 512'(exp_first));
    endtask

    function automatic logic [511:0] seq_bytes(input int nb);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < nb; i++) b[511-8*i -: 8] = 8'(i);
        return b;
    endfunction

    initial begin
        int n;
        logic [511:0] e;
        reset_n                 = 1'b0;
        bus.hmac_reset          = 1'b0;
        bus.hmac_start_continue = 1'b0;
        bus.hmac_data_available = 1'b0;
        bus.hmac_data_is_long   = 1'b0;
        bus.data_in             = '0;
        bus.digest              = DIGEST;
        core_en                 = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy",  512'(bus.hmac_busy),  512'd0);
        check("rst_out",   512'(bus.hmac_out),   512'd0);
        check("rst_err",   512'(bus.hmac_error), 512'd0);
        check("rst_valid", 512'(bus.blk_valid),  512'd0);
        check("rst_first", 512'(bus.blk_first),  512'd0);
        check("rst_data",  bus.blk_data,         512'd0);

        // clear while a block sits in SEND
        for (int i = 0; i < 31; i++) send_word(16'h1111);
        cmd(1'b1, 1'b1, 16'h2222);
        @(negedge clk);
        check("send_valid", 512'(bus.blk_valid), 512'd1);
        check("send_first", 512'(bus.blk_first), 512'd1);
        cmd(1'b1, 1'b1, 16'h3333);
        check("send_busy_err", 512'(bus.hmac_error), 512'd1);
        clear_ctx();
        check("clr_valid", 512'(bus.blk_valid),  512'd0);
        check("clr_busy",  512'(bus.hmac_busy),  512'd0);
        check("clr_err",   512'(bus.hmac_error), 512'd0);
        core_en = 1'b1;

        // "abc"
        cmd(1'b1, 1'b1, 16'h6162);
        check("lat_busy1", 512'(bus.hmac_busy), 512'd1);
        @(negedge clk);
        check("lat_busy0", 512'(bus.hmac_busy), 512'd0);
        cmd(1'b1, 1'b0, 16'h0063);
        wait_ready("abc_byte", n);
        cmd(1'b0, 1'b0, 16'h0000);
        wait_ready("abc_fin", n);
        check("abc_nblk", 512'(blk_q.size()), 512'd1);
        e = '0;
        e[511:480] = 32'h61626380;
        e[63:0]    = 64'h18;
        pop_blk("abc_blk", e, 1'b1);
        check("abc_out0", 512'(bus.hmac_out), 512'(dig_words[0]));

        // digest advance and wrap
        for (int k = 1; k <= 17; k++) begin
            cmd(1'b0, 1'b0, 16'h0000);
            check("adv_busy", 512'(bus.hmac_busy), 512'd1);
            @(negedge clk);
            check("adv_out", 512'(bus.hmac_out), 512'(dig_words[k % 16]));
        end
        check("adv_err", 512'(bus.hmac_error), 512'd0);
        cmd(1'b1, 1'b1, 16'hffff);
        check("out_data_err", 512'(bus.hmac_error), 512'd1);
        check("out_data_keep", 512'(bus.hmac_out), 512'(dig_words[1]));
        clear_ctx();
        check("clr_err2", 512'(bus.hmac_error), 512'd0);

        // 56 bytes -> two blocks
        for (int i = 0; i < 28; i++) send_word({8'(2*i), 8'(2*i+1)});
        cmd(1'b0, 1'b0, 16'h0000);
        wait_ready("b56_fin", n);
        check("b56_nblk", 512'(blk_q.size()), 512'd2);
        e = seq_bytes(56) | (512'h80 << 56);
        pop_blk("b56_blk1", e, 1'b1);
        pop_blk("b56_blk2", 512'h1c0, 1'b0);
        check("b56_out0", 512'(bus.hmac_out), 512'(dig_words[0]));
        clear_ctx();

        // 64 bytes: block handed off on the last word
        for (int i = 0; i < 31; i++) send_word({8'(2*i), 8'(2*i+1)});
        cmd(1'b1, 1'b1, 16'h3e3f);
        check("b64_busy", 512'(bus.hmac_busy), 512'd1);
        wait_ready("b64_ready", n);
        check("b64_busy_cycles", 512'(n), 512'd5);
        check("b64_nblk1", 512'(blk_q.size()), 512'd1);
        pop_blk("b64_blk1", seq_bytes(64), 1'b1);
        cmd(1'b0, 1'b0, 16'h0000);
        wait_ready("b64_fin", n);
        e = (512'h80 << 504) | 512'h200;
        pop_blk("b64_blk2", e, 1'b0);
        clear_ctx();

        // word after byte
        cmd(1'b1, 1'b0, 16'h0041);
        wait_ready("wab_byte", n);
        cmd(1'b1, 1'b1, 16'h4243);
        check("wab_err", 512'(bus.hmac_error), 512'd1);
        check("wab_nobusy", 512'(bus.hmac_busy), 512'd0);
        cmd(1'b0, 1'b0, 16'h0000);
        wait_ready("wab_fin", n);
        e = '0;
        e[511:496] = 16'h4180;
        e[63:0]    = 64'h8;
        pop_blk("wab_blk", e, 1'b1);
        clear_ctx();

        // strobe held into the busy cycle
        @(negedge clk);
        bus.hmac_start_continue = 1'b1;
        bus.hmac_data_available = 1'b1;
        bus.hmac_data_is_long   = 1'b1;
        bus.data_in             = 16'h1234;
        @(negedge clk);
        bus.data_in = 16'h5678;
        @(negedge clk);
        bus.hmac_start_continue = 1'b0;
        wait_ready("bsy_ready", n);
        check("bsy_err", 512'(bus.hmac_error), 512'd1);
        cmd(1'b0, 1'b0, 16'h0000);
        wait_ready("bsy_fin", n);
        e = '0;
        e[511:488] = 24'h123480;
        e[63:0]    = 64'h10;
        pop_blk("bsy_blk", e, 1'b1);
        clear_ctx();
        check("final_err", 512'(bus.hmac_error), 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
